ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 35 +++
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding and requester count.
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers which requester was served last.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic last;

  always_comb begin
    grant = '0;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  // Resetting to "1 served last" hands the first contended grant to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-port RAM: one operation every three cycles,
// with a one-cycle completion pulse returned to the requester that was served.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 8,
  parameter int MEM_WIDTH  = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [NUM_REQ-1:0]           rsp_err,
  output logic [MEM_WIDTH-1:0]         rsp_rdata,
  output logic                         WrEn,
  output logic                         RdEn,
  output logic [ADDR_WIDTH-1:0]        address,
  output logic [MEM_WIDTH-1:0]         WrData,
  input  logic [MEM_WIDTH-1:0]         RdData
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t               state;
  logic [NUM_REQ-1:0]   grant;
  logic                 sel_id;
  logic                 sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_WIDTH-1:0] sel_wdata;
  logic                 sel_in_range;
  logic                 lat_id;
  logic                 lat_we;
  logic                 lat_err;

  rr_arbiter2 u_rr (
    .clk    (CLK),
    .rst    (RST),
    .req    (req_valid),
    .enable (state == IDLE && !RST),
    .grant  (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_id       = grant[1];
    sel_we       = sel_id ? req_we[1] : req_we[0];
    sel_addr     = sel_id ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    sel_wdata    = sel_id ? req_wdata[MEM_WIDTH +: MEM_WIDTH] : req_wdata[0 +: MEM_WIDTH];
    sel_in_range = {1'b0, sel_addr} < DEPTH_LIMIT;
  end

  // RdData only settles on the edge that ends the strobe cycle, so it is forwarded straight through.
  assign rsp_rdata = (state == RESP && !lat_we && !lat_err) ? RdData : '0;

  // The address/WrData registers double as the request latch and hold between operations.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      address   <= '0;
      WrData    <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= '0;
          rsp_err   <= '0;
          if (|grant) begin
            lat_id  <= sel_id;
            lat_we  <= sel_we;
            lat_err <= !sel_in_range;
            address <= sel_addr;
            WrData  <= sel_wdata;
            WrEn    <= sel_we && sel_in_range;
            RdEn    <= !sel_we && sel_in_range;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          WrEn      <= 1'b0;
          RdEn      <= 1'b0;
          rsp_valid <= lat_id ? 2'b10 : 2'b01;
          rsp_err   <= lat_err ? (lat_id ? 2'b10 : 2'b01) : 2'b00;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_err   <= '0;
          state     <= IDLE;
        end
        default: begin
          WrEn      <= 1'b0;
          RdEn      <= 1'b0;
          rsp_valid <= '0;
          rsp_err   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM attached to the strobe port.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int MW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*MW-1:0] req_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_err;
  logic [MW-1:0] rsp_rdata;
  logic          WrEn;
  logic          RdEn;
  logic [AW-1:0] address;
  logic [MW-1:0] WrData;
  logic [MW-1:0] RdData;

  int errors = 0;
  int checks = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int both_high = 0;

  logic [MW-1:0] mem [0:15];

  ram_arbiter #(.ADDR_WIDTH(AW), .MEM_DEPTH(8), .MEM_WIDTH(MW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .address   (address),
    .WrData    (WrData),
    .RdData    (RdData)
  );

  always #5 CLK = ~CLK;

  // RAM model: registered read, and both strobes together clear the word.
  always @(posedge CLK) begin
    if (WrEn && RdEn) mem[address] <= '0;
    else if (WrEn) mem[address] <= WrData;
    if (RdEn) RdData <= mem[address];
  end

  always @(negedge CLK) begin
    if (WrEn) wr_cycles++;
    if (RdEn) rd_cycles++;
    if (WrEn && RdEn) both_high++;
  end

  task automatic test_reset();
    RST = 1'b1;
    req_valid = 2'b11;
    @(negedge CLK); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin errors++; $display("[TB] FAIL rst_rsp got=%b/%b exp=00/00", rsp_valid, rsp_err); end
    checks++; if (WrEn !== 1'b0 || RdEn !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobe got=%b%b exp=00", WrEn, RdEn); end
    checks++; if (address !== '0 || WrData !== '0 || rsp_rdata !== '0) begin errors++; $display("[TB] FAIL rst_data got=%h/%h/%h exp=0/0/0", address, WrData, rsp_rdata); end
    @(negedge CLK);
    RST = 1'b0;
    req_valid = 2'b00;
    @(negedge CLK);
  endtask

  task automatic test_single_write();
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = {4'd0, 4'd3}; req_wdata = {16'h0000, 16'hA5A5};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL wr_ready got=%b exp=01", req_ready); end
    @(negedge CLK);
    req_valid = 2'b00; req_we = 2'b00;
    req_addr = {4'd5, 4'd5}; req_wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (WrEn !== 1'b1 || RdEn !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobe got=%b%b exp=10", WrEn, RdEn); end
    checks++; if (address !== 4'd3 || WrData !== 16'hA5A5) begin errors++; $display("[TB] FAIL wr_bus got=%h/%h exp=3/a5a5", address, WrData); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL wr_early_rsp got=%b exp=00", rsp_valid); end
    @(negedge CLK); #1;
    checks++; if (WrEn !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobe_len got=%b exp=0", WrEn); end
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 2'b00) begin errors++; $display("[TB] FAIL wr_rsp got=%b/%b exp=01/00", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL wr_rdata got=%h exp=0000", rsp_rdata); end
    checks++; if (address !== 4'd3 || WrData !== 16'hA5A5) begin errors++; $display("[TB] FAIL wr_hold got=%h/%h exp=3/a5a5", address, WrData); end
    @(negedge CLK); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL wr_pulse_len got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_read_back();
    req_valid = 2'b10; req_we = 2'b00; req_addr = {4'd3, 4'd0};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL rd_ready got=%b exp=10", req_ready); end
    @(negedge CLK);
    req_valid = 2'b00;
    #1;
    checks++; if (RdEn !== 1'b1 || WrEn !== 1'b0 || address !== 4'd3) begin errors++; $display("[TB] FAIL rd_strobe got=%b%b@%h exp=01@3", WrEn, RdEn, address); end
    @(negedge CLK); #1;
    checks++; if (RdEn !== 1'b0) begin errors++; $display("[TB] FAIL rd_strobe_len got=%b exp=0", RdEn); end
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 2'b00) begin errors++; $display("[TB] FAIL rd_rsp got=%b/%b exp=10/00", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 16'hA5A5) begin errors++; $display("[TB] FAIL rd_rdata got=%h exp=a5a5", rsp_rdata); end
    @(negedge CLK); #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rd_pulse_len got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_contention();
    int wr0 = wr_cycles;
    int rd0 = rd_cycles;
    int bh0 = both_high;
    logic [1:0] exp_mask;
    req_valid = 2'b11; req_we = 2'b01;
    req_addr = {4'd1, 4'd1}; req_wdata = {16'h0000, 16'h1111};
    for (int c = 0; c < 12; c++) begin
      exp_mask = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== ((c % 3 == 0) ? exp_mask : 2'b00)) begin
        errors++; $display("[TB] FAIL cont_ready c=%0d got=%b exp=%b", c, req_ready, (c % 3 == 0) ? exp_mask : 2'b00);
      end
      checks++;
      if (rsp_valid !== ((c % 3 == 2) ? exp_mask : 2'b00)) begin
        errors++; $display("[TB] FAIL cont_rsp c=%0d got=%b exp=%b", c, rsp_valid, (c % 3 == 2) ? exp_mask : 2'b00);
      end
      if (c == 5 || c == 11) begin
        checks++; if (rsp_rdata !== 16'h1111) begin errors++; $display("[TB] FAIL cont_rdata c=%0d got=%h exp=1111", c, rsp_rdata); end
      end
      @(negedge CLK);
    end
    req_valid = 2'b00;
    checks++; if (both_high - bh0 != 0) begin errors++; $display("[TB] FAIL cont_both_strobes got=%0d exp=0", both_high - bh0); end
    checks++; if (wr_cycles - wr0 != 2 || rd_cycles - rd0 != 2) begin errors++; $display("[TB] FAIL cont_strobe_count got=%0d/%0d exp=2/2", wr_cycles - wr0, rd_cycles - rd0); end
  endtask

  task automatic test_out_of_range();
    int wr0 = wr_cycles;
    int rd0 = rd_cycles;
    req_valid = 2'b01; req_we = 2'b00; req_addr = {4'd0, 4'd9};
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL oor_ready got=%b exp=01", req_ready); end
    @(negedge CLK);
    req_valid = 2'b00;
    #1;
    checks++; if (WrEn !== 1'b0 || RdEn !== 1'b0) begin errors++; $display("[TB] FAIL oor_strobe got=%b%b exp=00", WrEn, RdEn); end
    @(negedge CLK); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 2'b01) begin errors++; $display("[TB] FAIL oor_rsp got=%b/%b exp=01/01", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL oor_rdata got=%h exp=0000", rsp_rdata); end
    @(negedge CLK); #1;
    checks++; if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin errors++; $display("[TB] FAIL oor_pulse_len got=%b/%b exp=00/00", rsp_valid, rsp_err); end
    checks++; if (wr_cycles != wr0 || rd_cycles != rd0) begin errors++; $display("[TB] FAIL oor_no_strobe got=%0d/%0d exp=0/0", wr_cycles - wr0, rd_cycles - rd0); end
  endtask

  task automatic test_reset_in_access();
    req_valid = 2'b11; req_we = 2'b11;
    req_addr = {4'd2, 4'd2}; req_wdata = {16'h2222, 16'h3333};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL rra_ready got=%b exp=10", req_ready); end
    @(negedge CLK); #1;
    checks++; if (WrEn !== 1'b1 || address !== 4'd2 || WrData !== 16'h2222) begin errors++; $display("[TB] FAIL rra_strobe got=%b@%h/%h exp=1@2/2222", WrEn, address, WrData); end
    RST = 1'b1;
    #1;
    checks++; if (WrEn !== 1'b0 || RdEn !== 1'b0 || address !== '0 || WrData !== '0) begin errors++; $display("[TB] FAIL rra_ram_outs got=%b%b %h/%h exp=00 0/0", WrEn, RdEn, address, WrData); end
    checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 || rsp_rdata !== '0) begin errors++; $display("[TB] FAIL rra_rsp_outs got=%b %b %b %h exp=00 00 00 0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rra_next_grant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      checks++; if (rsp_valid !== 2'b00 || WrEn !== 1'b0) begin errors++; $display("[TB] FAIL rra_quiet c=%0d got=%b/%b exp=00/0", c, rsp_valid, WrEn); end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_out_of_range();
    test_reset_in_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
